// File: rtl/mix_sequencer.sv
// mix_sequencer: divides sys_clk into sample frames, decodes oscillator slots and
// stages volume/voice-mask updates so they only take effect at frame boundaries.
`ifndef N_OSCILLATORS
`define N_OSCILLATORS 16
`endif
module mix_sequencer #(
    parameter int N_WAVEGENS   = `N_OSCILLATORS,
    parameter int FRAME_CYCLES = 384
) (
    input  logic                            sys_clk,
    input  logic                            rstn,
    input  logic                            run,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [31:0]                     cfg_volume,
    input  logic [N_WAVEGENS-1:0]           cfg_voice_mask,
    output logic [31:0]                     master_volume,
    output logic [8:0]                      clk_counter,
    output logic [$clog2(N_WAVEGENS+1)-1:0] index,
    output logic                            voice_enable,
    output logic                            sample_clk,
    output logic                            sample_tick,
    output logic                            busy,
    output logic                            cfg_applied
);
    localparam int IW = $clog2(N_WAVEGENS + 1);
    localparam logic [8:0] LAST = 9'(FRAME_CYCLES - 1);
    localparam logic [8:0] HALF = 9'(FRAME_CYCLES / 2);
    localparam logic [8:0] NW = 9'(N_WAVEGENS);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic pending, pending_n, apply, xfer;
    logic [8:0] cnt_n;
    logic [31:0] stage_volume, volume_n;
    logic [N_WAVEGENS-1:0] stage_mask, mask, mask_n;
    // Decode is computed from the next counter so every output lands in the same cycle as it.
    always_comb begin
        xfer = cfg_valid && cfg_ready;
        apply = pending && (state == IDLE || clk_counter == LAST);
        pending_n = apply ? 1'b0 : (xfer ? 1'b1 : pending);
        volume_n = apply ? stage_volume : master_volume;
        mask_n = apply ? stage_mask : mask;
        state_n = ((state == RUN && clk_counter != LAST) || run) ? RUN : IDLE;
        cnt_n = (state_n == IDLE) ? LAST : ((state == RUN && clk_counter != LAST) ? clk_counter + 9'd1 : 9'd0);
    end
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            clk_counter <= LAST;
            index <= IW'(N_WAVEGENS);
            voice_enable <= 1'b0;
            sample_clk <= 1'b0;
            sample_tick <= 1'b0;
            busy <= 1'b0;
            cfg_applied <= 1'b0;
            cfg_ready <= 1'b1;
            pending <= 1'b0;
            master_volume <= '0;
            mask <= '0;
            stage_volume <= '0;
            stage_mask <= '0;
        end else begin
            state <= state_n;
            clk_counter <= cnt_n;
            index <= (cnt_n < NW) ? cnt_n[IW-1:0] : IW'(N_WAVEGENS);
            voice_enable <= |(mask_n & (N_WAVEGENS'(1) << cnt_n));
            sample_clk <= state_n == RUN && cnt_n >= HALF;
            sample_tick <= state_n == RUN && cnt_n == LAST;
            busy <= state_n == RUN;
            cfg_applied <= apply;
            cfg_ready <= !pending_n;
            pending <= pending_n;
            master_volume <= volume_n;
            mask <= mask_n;
            if (xfer) begin
                stage_volume <= cfg_volume;
                stage_mask <= cfg_voice_mask;
            end
        end
    end
endmodule

// File: tb/tb_mix_sequencer.sv
// tb_mix_sequencer: directed checks of frame timing, slot decode and boundary-synchronous config.
`timescale 1ns/1ps
module tb_mix_sequencer;
    localparam int N = 16, FC = 384;
    logic sys_clk = 1'b0, rstn = 1'b0, run = 1'b0, cfg_valid = 1'b0;
    logic [31:0] cfg_volume = '0;
    logic [N-1:0] cfg_voice_mask = '0;
    logic cfg_ready, voice_enable, sample_clk, sample_tick, busy, cfg_applied;
    logic [31:0] master_volume;
    logic [8:0] clk_counter;
    logic [4:0] index;
    int checks = 0, errors = 0, n;

    always #5 sys_clk = ~sys_clk;

    mix_sequencer #(.N_WAVEGENS(N), .FRAME_CYCLES(FC)) dut (
        .sys_clk(sys_clk), .rstn(rstn), .run(run), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_volume(cfg_volume), .cfg_voice_mask(cfg_voice_mask), .master_volume(master_volume),
        .clk_counter(clk_counter), .index(index), .voice_enable(voice_enable), .sample_clk(sample_clk),
        .sample_tick(sample_tick), .busy(busy), .cfg_applied(cfg_applied)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge sys_clk);
    endtask

    initial begin
        step(2);
        check("rst_cnt", clk_counter, 383);
        check("rst_idx", index, 16);
        check("rst_ve", voice_enable, 0);
        check("rst_sclk", sample_clk, 0);
        check("rst_tick", sample_tick, 0);
        check("rst_busy", busy, 0);
        check("rst_applied", cfg_applied, 0);
        check("rst_ready", cfg_ready, 1);
        check("rst_vol", master_volume, 0);
        rstn = 1'b1;
        step(1);
        check("idle_cnt", clk_counter, 383);
        check("idle_busy", busy, 0);
        // config while idle applies one cycle after transfer
        cfg_valid = 1'b1; cfg_volume = 32'h100; cfg_voice_mask = 16'h0005;
        step(1);
        check("idle_ready_low", cfg_ready, 0);
        check("idle_applied_early", cfg_applied, 0);
        cfg_valid = 1'b0;
        step(1);
        check("idle_applied", cfg_applied, 1);
        check("idle_ready_back", cfg_ready, 1);
        check("idle_vol", master_volume, 32'h100);
        step(1);
        check("idle_applied_clr", cfg_applied, 0);
        // one full frame against the expected decode
        run = 1'b1;
        step(1);
        for (int c = 0; c < FC; c++) begin
            check("cnt", clk_counter, c);
            check("idx", index, (c < N) ? c : N);
            check("ve", voice_enable, (c == 0 || c == 2) ? 1 : 0);
            check("sclk", sample_clk, (c >= FC / 2) ? 1 : 0);
            check("tick", sample_tick, (c == FC - 1) ? 1 : 0);
            check("busy", busy, 1);
            if (c < FC - 1) step(1);
        end
        n = 0;
        do begin
            step(1);
            n++;
        end while (!sample_tick && n < 1000);
        check("tick_period", n, FC);
        step(1);
        check("wrap_cnt", clk_counter, 0);
        // volume offered mid-frame applies at the next boundary
        step(100);
        check("c100", clk_counter, 100);
        cfg_valid = 1'b1; cfg_volume = 32'h0001_0000;
        step(1);
        check("mid_ready_low", cfg_ready, 0);
        check("mid_vol_hold", master_volume, 32'h100);
        cfg_valid = 1'b0;
        step(282);
        check("c383", clk_counter, 383);
        check("mid_vol_hold_end", master_volume, 32'h100);
        check("mid_applied_early", cfg_applied, 0);
        step(1);
        check("mid_cnt0", clk_counter, 0);
        check("mid_vol", master_volume, 32'h0001_0000);
        check("mid_applied", cfg_applied, 1);
        check("mid_ready_back", cfg_ready, 1);
        // transfer in the boundary cycle waits a whole frame; second offer refused
        step(383);
        check("b_c383", clk_counter, 383);
        cfg_valid = 1'b1; cfg_volume = 32'h2222_2222;
        step(1);
        check("b_vol_hold", master_volume, 32'h0001_0000);
        check("b_applied_none", cfg_applied, 0);
        check("b_ready_low", cfg_ready, 0);
        cfg_volume = 32'h3333_3333;
        step(5);
        check("b_ready_still_low", cfg_ready, 0);
        cfg_valid = 1'b0;
        step(378);
        check("b_c383b", clk_counter, 383);
        check("b_vol_hold_end", master_volume, 32'h0001_0000);
        step(1);
        check("b_vol", master_volume, 32'h2222_2222);
        check("b_applied", cfg_applied, 1);
        step(1);
        check("b_vol_stable", master_volume, 32'h2222_2222);
        check("b_ready_back", cfg_ready, 1);
        // run dropped mid-frame: frame completes then holds in idle
        step(49);
        check("s_c50", clk_counter, 50);
        run = 1'b0;
        step(333);
        check("s_c383", clk_counter, 383);
        check("s_busy_end", busy, 1);
        check("s_tick", sample_tick, 1);
        check("s_sclk", sample_clk, 1);
        step(1);
        check("s_idle_cnt", clk_counter, 383);
        check("s_idle_busy", busy, 0);
        check("s_idle_sclk", sample_clk, 0);
        check("s_idle_tick", sample_tick, 0);
        check("s_idle_idx", index, 16);
        step(3);
        check("s_hold_cnt", clk_counter, 383);
        check("s_hold_busy", busy, 0);
        run = 1'b1;
        step(1);
        check("s_restart_cnt", clk_counter, 0);
        check("s_restart_busy", busy, 1);
        // run re-asserted in the last frame cycle: no idle gap
        step(10);
        run = 1'b0;
        step(373);
        check("r_c383", clk_counter, 383);
        run = 1'b1;
        step(1);
        check("r_cnt0", clk_counter, 0);
        check("r_busy", busy, 1);
        // stop and apply at the same boundary
        step(100);
        cfg_valid = 1'b1; cfg_volume = 32'h44; cfg_voice_mask = 16'h0002;
        run = 1'b0;
        step(1);
        cfg_valid = 1'b0;
        step(282);
        check("j_c383", clk_counter, 383);
        check("j_vol_hold", master_volume, 32'h2222_2222);
        step(1);
        check("j_idle_cnt", clk_counter, 383);
        check("j_busy", busy, 0);
        check("j_vol", master_volume, 32'h44);
        check("j_applied", cfg_applied, 1);
        step(1);
        check("j_applied_clr", cfg_applied, 0);
        check("j_ready", cfg_ready, 1);
        run = 1'b1;
        step(1);
        check("m_cnt0", clk_counter, 0);
        check("m_ve0", voice_enable, 0);
        step(1);
        check("m_ve1", voice_enable, 1);
        // asynchronous reset mid-frame with a pending update
        step(199);
        check("x_c200", clk_counter, 200);
        cfg_valid = 1'b1; cfg_volume = 32'h55;
        step(1);
        check("x_ready_low", cfg_ready, 0);
        cfg_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("x_cnt", clk_counter, 383);
        check("x_busy", busy, 0);
        check("x_ready", cfg_ready, 1);
        check("x_vol", master_volume, 0);
        check("x_idx", index, 16);
        check("x_sclk", sample_clk, 0);
        step(1);
        run = 1'b0;
        rstn = 1'b1;
        step(2);
        check("x_post_vol", master_volume, 0);
        check("x_post_applied", cfg_applied, 0);
        check("x_post_ready", cfg_ready, 1);
        check("x_post_cnt", clk_counter, 383);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
